// File: rtl/shift_pkg.sv
// Shared definitions for the inverse-shift datapath: op codes, FSM encoding
// and op classification helpers.
package shift_pkg;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASL = 3'b010;
    localparam logic [2:0] OP_ASR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Op codes 11x carry no shift, so the word passes through untouched.
    function automatic logic is_passthru(input logic [2:0] op);
        return (op[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single-position inverse of one forward shift op, plus a flag that goes high
// when the bit being discarded could not have been a fill bit of the forward op.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] next_data,
    output logic             drop_bad
);

    // One inverse step selected by the forward op code.
    always_comb begin
        next_data = data;
        drop_bad  = 1'b0;
        case (op)
            OP_LSL, OP_ASL: begin
                next_data = {1'b0, data[WIDTH-1:1]};
                drop_bad  = data[0];
            end
            OP_LSR: begin
                next_data = {data[WIDTH-2:0], 1'b0};
                drop_bad  = data[WIDTH-1];
            end
            OP_ASR: begin
                // Arithmetic right shift replicates the sign, so the top two bits must agree.
                next_data = {data[WIDTH-2:0], 1'b0};
                drop_bad  = data[WIDTH-1] ^ data[WIDTH-2];
            end
            OP_ROL: begin
                next_data = {data[0], data[WIDTH-1:1]};
                drop_bad  = 1'b0;
            end
            OP_ROR: begin
                next_data = {data[WIDTH-2:0], data[WIDTH-1]};
                drop_bad  = 1'b0;
            end
            default: begin
                next_data = data;
                drop_bad  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_undo_seq.sv
// Multi-cycle inverse shifter: undoes one bit position per clock and reports
// inputs that no forward shift could have produced.
module shift_undo_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_inconsistent,
    output logic             busy
);

    state_t             state_r;
    state_t             state_next_s;
    logic [AMT_W-1:0]   count_r;
    logic [WIDTH-1:0]   work_r;
    logic [2:0]         op_r;
    logic               flag_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_data_r;
    logic               out_flag_r;

    logic [AMT_W-1:0]   amt_s;
    logic               accept_s;
    logic [WIDTH-1:0]   step_data_s;
    logic               step_bad_s;
    logic [WIDTH-1:0]   result_data_s;
    logic               result_flag_s;
    logic               in_ready_s;
    logic               busy_s;

    // Amounts past WIDTH-1 only exist when WIDTH is not a power of two.
    if (WIDTH == (1 << AMT_W)) begin : g_no_clamp
        assign amt_s = in_amt;
    end else begin : g_clamp
        assign amt_s = (in_amt > AMT_W'(WIDTH - 1)) ? AMT_W'(WIDTH - 1) : in_amt;
    end

    assign accept_s = in_valid & in_ready_s;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data      (work_r),
        .op        (op_r),
        .next_data (step_data_s),
        .drop_bad  (step_bad_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if ((amt_s == {AMT_W{1'b0}}) || is_passthru(in_op)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (count_r == AMT_W'(1)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b1;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ST_SHIFT, ST_DONE: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // Working data, remaining count and sticky inconsistency flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_r  <= {WIDTH{1'b0}};
            op_r    <= 3'b000;
            count_r <= {AMT_W{1'b0}};
            flag_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        work_r  <= in_data;
                        op_r    <= in_op;
                        count_r <= amt_s;
                        flag_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    work_r  <= step_data_s;
                    count_r <= count_r - AMT_W'(1);
                    flag_r  <= flag_r | step_bad_s;
                end
                default: begin
                    work_r <= work_r;
                end
            endcase
        end
    end

    // Result that gets captured on the way into DONE.
    always_comb begin
        result_data_s = step_data_s;
        result_flag_s = flag_r | step_bad_s;
        if (state_r == ST_IDLE) begin
            result_data_s = in_data;
            result_flag_s = 1'b0;
        end else begin
            result_data_s = step_data_s;
            result_flag_s = flag_r | step_bad_s;
        end
    end

    // Registered outputs, frozen for the whole DONE stay.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_flag_r  <= 1'b0;
        end else begin
            out_valid_r <= (state_next_s == ST_DONE);
            if ((state_next_s == ST_DONE) && (state_r != ST_DONE)) begin
                out_data_r <= result_data_s;
                out_flag_r <= result_flag_s;
            end
        end
    end

    assign in_ready         = in_ready_s;
    assign busy             = busy_s;
    assign out_valid        = out_valid_r;
    assign out_data         = out_data_r;
    assign out_inconsistent = out_flag_r;

endmodule

// File: tb/tb_shift_undo_seq.sv
// Self-checking bench for shift_undo_seq: directed cases with literal results
// plus randomized jobs checked against a whole-word arithmetic reference.
module tb_shift_undo_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_inconsistent;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_data;
    logic       exp_flag;

    shift_undo_seq #(.WIDTH(8), .AMT_W(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_amt           (in_amt),
        .in_op            (in_op),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_inconsistent (out_inconsistent),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Whole-word reference: undo the full shift amount at once.
    function automatic void model(input logic [7:0] d, input logic [2:0] op, input int amt,
                                  output logic [7:0] r, output logic f);
        int v;
        int t;
        v = int'(d);
        r = d;
        f = 1'b0;
        case (op)
            3'b000, 3'b010: begin
                r = 8'(v >> amt);
                f = (v & ((1 << amt) - 1)) != 0;
            end
            3'b001: begin
                r = 8'(v << amt);
                f = (v >> (8 - amt)) != 0;
            end
            3'b011: begin
                r = 8'(v << amt);
                t = v >> (7 - amt);
                f = !((t == 0) || (t == ((1 << (amt + 1)) - 1)));
            end
            3'b100: r = 8'((v >> amt) | (v << (8 - amt)));
            3'b101: r = 8'((v << amt) | (v >> (8 - amt)));
            default: begin
                r = d;
                f = 1'b0;
            end
        endcase
    endfunction

    // Per-cycle compare of everything the outputs promise.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                check("out_data", out_data, exp_data);
                check("out_inconsistent", out_inconsistent, exp_flag);
                check("in_ready_in_done", in_ready, 0);
                check("busy_in_done", busy, 1);
            end else if (in_ready) begin
                check("busy_in_idle", busy, 0);
            end
        end
    end

    task automatic run_job(input logic [7:0] d, input logic [2:0] op, input logic [2:0] amt,
                           input logic [7:0] e_data, input logic e_flag, input int hold);
        int waited;
        int lat;
        int exp_lat;
        logic [7:0] held_data;
        logic       held_flag;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            return;
        end
        exp_data = e_data;
        exp_flag = e_flag;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_amt   = amt;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_op    = 3'($urandom);
        in_amt   = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        exp_lat = ((amt == 3'd0) || (op[2:1] == 2'b11)) ? 1 : int'(amt) + 1;
        check("latency", lat, exp_lat);
        if (!out_valid) return;
        held_data = out_data;
        held_flag = out_inconsistent;
        repeat (hold) @(negedge clk);
        check("held_valid", out_valid, 1);
        check("held_data", out_data, held_data);
        check("held_flag", out_inconsistent, held_flag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("after_hs_valid", out_valid, 0);
        check("after_hs_ready", in_ready, 1);
    endtask

    initial begin
        logic [7:0] rd;
        logic [2:0] rop;
        logic [2:0] ramt;
        logic [7:0] md;
        logic       mf;
        bit         rose;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_amt    = 3'd0;
        in_op     = 3'b000;
        out_ready = 1'b0;
        exp_data  = 8'h00;
        exp_flag  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_flag", out_inconsistent, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Reset in the middle of a ROL by 5 abandons the job.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_op    = 3'b100;
        in_amt   = 3'd5;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_ready", in_ready, 1);
        rose = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        check("post_rst_no_valid", rose, 0);

        run_job(8'hB4, 3'b100, 3'd3, 8'h96, 1'b0, 0);
        run_job(8'h58, 3'b000, 3'd3, 8'h0B, 1'b0, 0);
        run_job(8'h59, 3'b000, 3'd3, 8'h0B, 1'b1, 1);
        run_job(8'hF2, 3'b011, 3'd2, 8'hC8, 1'b0, 0);
        run_job(8'hB2, 3'b011, 3'd2, 8'hC8, 1'b1, 0);
        run_job(8'h3C, 3'b101, 3'd0, 8'h3C, 1'b0, 0);
        run_job(8'hA5, 3'b110, 3'd7, 8'hA5, 1'b0, 0);
        run_job(8'h81, 3'b001, 3'd1, 8'h02, 1'b1, 5);
        run_job(8'h0F, 3'b101, 3'd4, 8'hF0, 1'b0, 5);

        for (int i = 0; i < 80; i++) begin
            rd   = 8'($urandom);
            rop  = 3'($urandom);
            ramt = 3'($urandom);
            model(rd, rop, int'(ramt), md, mf);
            run_job(rd, rop, ramt, md, mf, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
